// File: rtl/fifo_arb_pkg.sv
// Shared arbiter types and the round-robin search used by the write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int RR_MAX_REQ = 32;
    localparam int RR_IDX_W   = 5;

    // First set bit strictly after `last`, wrapping modulo num_req; -1 when req_vec is empty.
    function automatic int rr_next(input logic [RR_MAX_REQ-1:0] req_vec,
                                   input int                    num_req,
                                   input int                    last);
        int pick;
        int idx;
        pick = -1;
        for (int k = RR_MAX_REQ; k >= 1; k--) begin
            if (k <= num_req) begin
                idx = last + k;
                if (idx >= num_req) begin
                    idx = idx - num_req;
                end
                if (req_vec[idx[RR_IDX_W-1:0]]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search over req starting just after last.
// Zero latency; no flow control of its own.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [RR_MAX_REQ-1:0] w_req_ext;
    int                    w_pick;

    assign w_req_ext = RR_MAX_REQ'(req);
    assign w_pick    = rr_next(w_req_ext, NUM_REQ, int'(last));
    assign found     = (w_pick >= 0);
    assign idx       = found ? w_pick[IDX_W-1:0] : '0;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin owner of the FIFO write port: one arbitration cycle, then up to MAX_BURST words.
// fifo_full stalls the owner with its word held; non-owner requests wait for the next IDLE.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          fifo_full,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic                          busy
);

    localparam int               IDX_W     = $clog2(NUM_REQ);
    localparam int               CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] r_last;
    logic [CNT_W-1:0] r_cnt;

    logic             w_found;
    logic [IDX_W-1:0] w_idx;
    logic             w_accept;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req   (req),
        .last  (r_last),
        .found (w_found),
        .idx   (w_idx)
    );

    // A reset cycle must not let the pending word slip into the FIFO.
    assign w_accept   = (r_state == BURST) && req[r_owner] && !fifo_full && !rst;
    assign fifo_wr_en = w_accept;
    assign gnt        = w_accept ? (NUM_REQ'(1) << r_owner) : '0;
    assign fifo_data  = w_accept ? req_data[r_owner*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign owner      = r_owner;
    assign busy       = (r_state == BURST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_last  <= IDX_W'(NUM_REQ - 1);
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_owner <= w_idx;
                        r_cnt   <= '0;
                        r_state <= BURST;
                    end
                end
                BURST: begin
                    if (!req[r_owner]) begin
                        r_state <= IDLE;
                        r_last  <= r_owner;
                    end else if (!fifo_full) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_BEAT) begin
                            r_state <= IDLE;
                            r_last  <= r_owner;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-cycle vector table, scoreboarded directed bursts,
// and a randomized 3-requester / single-word-burst instance.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 8;
    localparam int MB  = 4;
    localparam int NR2 = 3;
    localparam int MB2 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] req_data;
    logic             fifo_full;
    logic [NR-1:0]    gnt;
    logic             fifo_wr_en;
    logic [DW-1:0]    fifo_data;
    logic [1:0]       owner;
    logic             busy;

    logic              rst2;
    logic [NR2-1:0]    req2;
    logic [NR2*DW-1:0] req_data2;
    logic              full2;
    logic [NR2-1:0]    gnt2;
    logic              wr2;
    logic [DW-1:0]     data2;
    logic [1:0]        owner2;
    logic              busy2;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .fifo_full(fifo_full),
        .gnt(gnt), .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data), .owner(owner), .busy(busy)
    );

    fifo_wr_arbiter #(.NUM_REQ(NR2), .DATA_WIDTH(DW), .MAX_BURST(MB2)) dut2 (
        .clk(clk), .rst(rst2), .req(req2), .req_data(req_data2), .fifo_full(full2),
        .gnt(gnt2), .fifo_wr_en(wr2), .fifo_data(data2), .owner(owner2), .busy(busy2)
    );

    int checks   = 0;
    int failures = 0;
    int t;

    typedef struct {
        int         idx;
        logic [7:0] data;
        int         t;
    } exp_t;

    typedef struct {
        logic [NR-1:0] req;
        logic [7:0]    w0;
        logic          full;
        logic          wr;
        logic [NR-1:0] g;
        logic [7:0]    d;
        logic          busy;
    } vec_t;

    logic [7:0] wq [NR][$];
    exp_t       sb[$];
    logic [7:0] exp2 [NR2][$];
    int         wait2 [NR2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, act, exp, t);
        end
    endtask

    task automatic add_exp(input int idx, input int first, input int cnt, input int t0);
        exp_t e;
        for (int k = 0; k < cnt; k++) begin
            e.idx  = idx;
            e.data = 8'(first + k);
            e.t    = t0 + k;
            sb.push_back(e);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NR; i++) begin
            if (wq[i].size() > 0) begin
                req[i]              = 1'b1;
                req_data[i*DW +: DW] = wq[i][0];
            end else begin
                req[i]              = 1'b0;
                req_data[i*DW +: DW] = 8'hEE;
            end
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < NR; i++) wq[i].delete();
        sb.delete();
        rst       = 1'b1;
        req       = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_outputs", 64'({fifo_wr_en, gnt, fifo_data, owner, busy}), 64'(0));
        rst = 1'b0;
    endtask

    // One clock: drive from the requester queues, sample, score, retire granted words.
    task automatic cycle_step(input logic full_i, input logic rst_i);
        exp_t          e;
        logic [NR-1:0] eg;
        @(negedge clk);
        t++;
        fifo_full = full_i;
        rst       = rst_i;
        drive_reqs();
        #1;
        check("gnt_onehot0", 64'($onehot0(gnt)), 64'(1));
        check("wr_en_vs_gnt", 64'(fifo_wr_en), 64'(|gnt));
        if (fifo_full) check("no_write_when_full", 64'(fifo_wr_en), 64'(0));
        if (fifo_wr_en) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got gnt=%b data=%h at t=%0d, expected no write", gnt, fifo_data, t);
            end else begin
                e  = sb.pop_front();
                eg = NR'(1 << e.idx);
                check("write_gnt", 64'(gnt), 64'(eg));
                check("write_data", 64'(fifo_data), 64'(e.data));
                check("write_cycle", 64'(t), 64'(e.t));
            end
            for (int i = 0; i < NR; i++) begin
                if (gnt[i] && wq[i].size() > 0) void'(wq[i].pop_front());
            end
        end
    endtask

    task automatic run_random();
        logic [NR2-1:0] done;
        logic [7:0]     w;
        logic [7:0]     e;
        done = '0;
        rst2 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rand_reset_outputs", 64'({wr2, gnt2, data2, owner2, busy2}), 64'(0));
        rst2 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            req2 = req2 & ~done;
            for (int i = 0; i < NR2; i++) begin
                if (!req2[i] && $urandom_range(0, 2) != 0) begin
                    w                     = 8'($urandom);
                    req2[i]               = 1'b1;
                    req_data2[i*DW +: DW] = w;
                    exp2[i].push_back(w);
                    wait2[i] = 0;
                end
            end
            full2 = ($urandom_range(0, 3) == 0);
            #1;
            check("rand_gnt_onehot0", 64'($onehot0(gnt2)), 64'(1));
            check("rand_wr_en_vs_gnt", 64'(wr2), 64'(|gnt2));
            if (full2) check("rand_no_write_when_full", 64'(wr2), 64'(0));
            done = gnt2;
            for (int i = 0; i < NR2; i++) begin
                if (gnt2[i]) begin
                    if (exp2[i].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rand_spurious_gnt: got gnt2=%b, expected no grant to %0d", gnt2, i);
                    end else begin
                        e = exp2[i].pop_front();
                        check("rand_write_data", 64'(data2), 64'(e));
                    end
                end else if (req2[i] && wr2) begin
                    wait2[i]++;
                    check("rand_starvation", 64'(wait2[i] <= NR2), 64'(1));
                end
            end
        end
    endtask

    vec_t vt [14];

    initial begin
        rst = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0;
        rst2 = 1'b1; req2 = '0; req_data2 = '0; full2 = 1'b0;
        t = 0;

        // Single requester: burst of 4, arbitration gap, short burst, then a full stall.
        vt[0]  = '{4'b0001, 8'hA0, 1'b0, 1'b0, 4'b0000, 8'h00, 1'b0};
        vt[1]  = '{4'b0001, 8'hA0, 1'b0, 1'b1, 4'b0001, 8'hA0, 1'b1};
        vt[2]  = '{4'b0001, 8'hA1, 1'b0, 1'b1, 4'b0001, 8'hA1, 1'b1};
        vt[3]  = '{4'b0001, 8'hA2, 1'b0, 1'b1, 4'b0001, 8'hA2, 1'b1};
        vt[4]  = '{4'b0001, 8'hA3, 1'b0, 1'b1, 4'b0001, 8'hA3, 1'b1};
        vt[5]  = '{4'b0001, 8'hA4, 1'b0, 1'b0, 4'b0000, 8'h00, 1'b0};
        vt[6]  = '{4'b0001, 8'hA4, 1'b0, 1'b1, 4'b0001, 8'hA4, 1'b1};
        vt[7]  = '{4'b0001, 8'hA5, 1'b0, 1'b1, 4'b0001, 8'hA5, 1'b1};
        vt[8]  = '{4'b0000, 8'h00, 1'b0, 1'b0, 4'b0000, 8'h00, 1'b1};
        vt[9]  = '{4'b0000, 8'h00, 1'b0, 1'b0, 4'b0000, 8'h00, 1'b0};
        vt[10] = '{4'b0001, 8'hB0, 1'b1, 1'b0, 4'b0000, 8'h00, 1'b0};
        vt[11] = '{4'b0001, 8'hB0, 1'b1, 1'b0, 4'b0000, 8'h00, 1'b1};
        vt[12] = '{4'b0001, 8'hB0, 1'b0, 1'b1, 4'b0001, 8'hB0, 1'b1};
        vt[13] = '{4'b0000, 8'h00, 1'b0, 1'b0, 4'b0000, 8'h00, 1'b1};

        do_reset();
        for (int r = 0; r < 14; r++) begin
            @(negedge clk);
            req       = vt[r].req;
            req_data  = {8'hEE, 8'hEE, 8'hEE, vt[r].w0};
            fifo_full = vt[r].full;
            #1;
            check($sformatf("vec%0d", r), 64'({fifo_wr_en, gnt, fifo_data, busy}),
                  64'({vt[r].wr, vt[r].g, vt[r].d, vt[r].busy}));
        end

        // All four requesting; requester 1 sees full for three cycles after its second write.
        do_reset();
        t = -1;
        for (int n = 0; n < 8; n++) wq[0].push_back(8'(n));
        for (int i = 1; i < NR; i++)
            for (int n = 0; n < 4; n++) wq[i].push_back(8'((i << 4) | n));
        add_exp(0, 'h00, 4, 1);
        add_exp(1, 'h10, 2, 6);
        add_exp(1, 'h12, 2, 11);
        add_exp(2, 'h20, 4, 14);
        add_exp(3, 'h30, 4, 19);
        add_exp(0, 'h04, 4, 24);
        for (int c = 0; c < 32; c++) begin
            int nt;
            nt = t + 1;
            cycle_step(nt >= 8 && nt <= 10, 1'b0);
        end
        check("rr_all_drained", 64'(sb.size()), 64'(0));

        // Requester 2 drops after two words while 3 waits.
        t = -1;
        wq[2].push_back(8'h24); wq[2].push_back(8'h25);
        wq[3].push_back(8'h34); wq[3].push_back(8'h35); wq[3].push_back(8'h36);
        add_exp(2, 'h24, 2, 1);
        add_exp(3, 'h34, 3, 5);
        for (int c = 0; c < 10; c++) cycle_step(1'b0, 1'b0);
        check("early_end_drained", 64'(sb.size()), 64'(0));

        // Reset mid-burst at cnt=2: pending word survives and requester 0 wins afterwards.
        do_reset();
        t = -1;
        for (int n = 0; n < 4; n++) wq[1].push_back(8'(8'h40 + n));
        add_exp(1, 'h40, 2, 1);
        add_exp(0, 'h0F, 1, 5);
        add_exp(1, 'h42, 2, 8);
        for (int c = 0; c < 3; c++) cycle_step(1'b0, 1'b0);
        cycle_step(1'b0, 1'b1);
        check("rst_cycle_no_write", 64'({fifo_wr_en, gnt}), 64'(0));
        wq[0].push_back(8'h0F);
        cycle_step(1'b0, 1'b0);
        check("post_rst_outputs", 64'({fifo_wr_en, gnt, fifo_data, owner, busy}), 64'(0));
        for (int c = 0; c < 8; c++) cycle_step(1'b0, 1'b0);
        check("rst_mid_burst_drained", 64'(sb.size()), 64'(0));

        run_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
